// File: rtl/frost32_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : frost32_mem_responder
// Description : Memory-side responder for the Frost32 CPU data port. Captures
//               a read/write request, waits a programmable number of cycles,
//               performs the access against an internal 32-bit word RAM and
//               returns read data with a one-cycle done strobe.
// Ports       : clk, rst (sync, active-high)
//               in_data/in_addr/in_access_type/in_access_size/in_req : request
//               out_data/out_done/out_error : completion, valid with out_done
//               out_busy : request in flight (ST_WAIT or ST_RESP)
// Revision    : 1.0 - initial release
// ============================================================================
module frost32_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic [31:0] in_addr,
    input  logic        in_access_type,
    input  logic [1:0]  in_access_size,
    input  logic        in_req,
    output logic [31:0] out_data,
    output logic        out_done,
    output logic        out_error,
    output logic        out_busy
);

    localparam int c_addr_w = $clog2(DEPTH_WORDS);
    localparam int c_cnt_w  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(LATENCY - 1);

    localparam logic [1:0] c_dias32 = 2'd0;
    localparam logic [1:0] c_dias16 = 2'd1;
    localparam logic [1:0] c_dias8  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_count;
    logic [31:0]          r_data;
    logic [31:0]          r_addr;
    logic                 r_wr;
    logic [1:0]           r_size;

    logic [31:0]          r_mem [DEPTH_WORDS];

    logic [c_addr_w-1:0]  w_index;
    logic [31:0]          w_word;
    logic                 w_addr_hi_bad;
    logic                 w_error;
    logic                 w_access;
    logic                 w_do_write;
    logic [31:0]          w_rd_data;
    logic [31:0]          w_wr_word;

    assign w_index       = r_addr[c_addr_w+1:2];
    assign w_word        = r_mem[w_index];
    // Any address bit above the RAM's word index makes the access out of
    // range; rejecting it (rather than truncating) prevents silent aliasing.
    assign w_addr_hi_bad = (r_addr >> (c_addr_w + 2)) != 32'd0;
    assign w_access      = (r_state == ST_WAIT) && (r_count == '0);
    // rst wins over a write landing on the same edge.
    assign w_do_write    = w_access && r_wr && !w_error && !rst;
    assign out_busy      = (r_state != ST_IDLE);

    // Next state, error decode, read lane extraction and write lane merge.
    always_comb begin
        w_state_nxt = r_state;
        w_error     = w_addr_hi_bad;
        w_rd_data   = 32'd0;
        w_wr_word   = w_word;

        case (r_size)
            c_dias32: begin
                if (r_addr[1:0] != 2'b00) w_error = 1'b1;
                w_rd_data = w_word;
                w_wr_word = r_data;
            end
            c_dias16: begin
                if (r_addr[0]) w_error = 1'b1;
                w_rd_data[15:0] = w_word[{r_addr[1], 4'b0000} +: 16];
                w_wr_word[{r_addr[1], 4'b0000} +: 16] = r_data[15:0];
            end
            c_dias8: begin
                w_rd_data[7:0] = w_word[{r_addr[1:0], 3'b000} +: 8];
                w_wr_word[{r_addr[1:0], 3'b000} +: 8] = r_data[7:0];
            end
            default: w_error = 1'b1;
        endcase

        case (r_state)
            ST_IDLE: if (in_req)   w_state_nxt = ST_WAIT;
            ST_WAIT: if (w_access) w_state_nxt = ST_RESP;
            ST_RESP:               w_state_nxt = ST_IDLE;
            default:               w_state_nxt = ST_IDLE;
        endcase
    end

    // State, request capture and registered completion outputs. The output
    // registers default to zero so they are only non-zero in ST_RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_data    <= 32'd0;
            r_addr    <= 32'd0;
            r_wr      <= 1'b0;
            r_size    <= 2'd0;
            out_data  <= 32'd0;
            out_done  <= 1'b0;
            out_error <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            out_data  <= 32'd0;
            out_done  <= 1'b0;
            out_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_req) begin
                        r_data  <= in_data;
                        r_addr  <= in_addr;
                        r_wr    <= in_access_type;
                        r_size  <= in_access_size;
                        r_count <= c_cnt_init;
                    end
                end
                ST_WAIT: begin
                    if (w_access) begin
                        out_done  <= 1'b1;
                        out_error <= w_error;
                        out_data  <= (w_error || r_wr) ? 32'd0 : w_rd_data;
                    end else begin
                        r_count <= r_count - c_cnt_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_do_write) r_mem[w_index] <= w_wr_word;
    end

endmodule
`default_nettype wire

// File: tb/tb_frost32_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_frost32_mem_responder
// Description : Self-checking bench for frost32_mem_responder. Requests come
//               from a vector table plus hand-written sequences; expected
//               completions are queued with their due cycle and checked by a
//               monitor on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frost32_mem_responder;

    localparam int DEPTH_WORDS = 1024;
    localparam int LATENCY     = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic [31:0] in_addr = '0;
    logic        in_access_type = 1'b0;
    logic [1:0]  in_access_size = 2'd0;
    logic        in_req = 1'b0;
    logic [31:0] out_data;
    logic        out_done;
    logic        out_error;
    logic        out_busy;

    frost32_mem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .LATENCY     (LATENCY)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_addr        (in_addr),
        .in_access_type (in_access_type),
        .in_access_size (in_access_size),
        .in_req         (in_req),
        .out_data       (out_data),
        .out_done       (out_done),
        .out_error      (out_error),
        .out_busy       (out_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    localparam int NV = 24;
    vec_t vecs [NV];
    exp_t sb [$];

    int  checks   = 0;
    int  failures = 0;
    bit  mon_en   = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: every completion must match the oldest expectation, arrive on
    // its due cycle, and outputs must be quiet whenever out_done is low.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_data",  out_data, e.data);
                    chk("done_error", {31'd0, out_error}, {31'd0, e.err});
                    chk("done_cycle", cyc, e.due);
                    chk("done_busy",  {31'd0, out_busy}, 32'd1);
                end
            end else begin
                chk("idle_outputs", {out_data[31:1], out_data[0] | out_error}, 32'd0);
            end
        end
    end

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk("timeout_waiting_done", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        @(posedge clk); #1;
        in_access_type = wr;
        in_access_size = size;
        in_addr        = addr;
        in_data        = data;
        in_req         = 1'b1;
        e.data = exp_data; e.err = exp_err; e.due = cyc + LATENCY + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        // Scramble inputs after capture: the in-flight access must not see them.
        in_req         = 1'b0;
        in_data        = $urandom;
        in_addr        = $urandom;
        in_access_type = 1'($urandom);
        in_access_size = 2'($urandom);
        wait_drain();
    endtask

    initial begin
        // wr, size, addr, data, exp_data, exp_err  (size: 0=32,1=16,2=8,3=bad)
        vecs[0]  = '{1'b1, 2'd0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 2'd0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 2'd2, 32'h12,   32'hAAAAAA55, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 2'd0, 32'h10,   32'h0,        32'hDE55BEEF, 1'b0};
        vecs[4]  = '{1'b0, 2'd1, 32'h12,   32'h0,        32'h0000DE55, 1'b0};
        vecs[5]  = '{1'b0, 2'd2, 32'h13,   32'h0,        32'h000000DE, 1'b0};
        vecs[6]  = '{1'b0, 2'd0, 32'h11,   32'h0,        32'h0,        1'b1};
        vecs[7]  = '{1'b1, 2'd1, 32'h13,   32'h00001111, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 2'd3, 32'h0,    32'h0,        32'h0,        1'b1};
        vecs[9]  = '{1'b0, 2'd0, 32'h10,   32'h0,        32'hDE55BEEF, 1'b0};
        vecs[10] = '{1'b1, 2'd0, 32'h0,    32'hCAFEF00D, 32'h0,        1'b0};
        vecs[11] = '{1'b1, 2'd0, 32'h1000, 32'h0BADF00D, 32'h0,        1'b1};
        vecs[12] = '{1'b0, 2'd0, 32'h0,    32'h0,        32'hCAFEF00D, 1'b0};
        vecs[13] = '{1'b1, 2'd1, 32'h2,    32'hABCD1234, 32'h0,        1'b0};
        vecs[14] = '{1'b0, 2'd0, 32'h0,    32'h0,        32'h1234F00D, 1'b0};
        vecs[15] = '{1'b0, 2'd1, 32'h0,    32'h0,        32'h0000F00D, 1'b0};
        vecs[16] = '{1'b1, 2'd2, 32'h1,    32'hFFFFFF77, 32'h0,        1'b0};
        vecs[17] = '{1'b0, 2'd0, 32'h0,    32'h0,        32'h1234770D, 1'b0};
        vecs[18] = '{1'b0, 2'd2, 32'h2,    32'h0,        32'h00000034, 1'b0};
        vecs[19] = '{1'b1, 2'd0, 32'h80000000, 32'h11111111, 32'h0,    1'b1};
        vecs[20] = '{1'b1, 2'd0, 32'hFFC,  32'h01020304, 32'h0,        1'b0};
        vecs[21] = '{1'b0, 2'd0, 32'hFFC,  32'h0,        32'h01020304, 1'b0};
        vecs[22] = '{1'b0, 2'd0, 32'h0,    32'h0,        32'h1234770D, 1'b0};
        vecs[23] = '{1'b1, 2'd0, 32'h20,   32'h0F0F0F0F, 32'h0,        1'b0};

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_data",  out_data, 32'd0);
        chk("reset_out_done",  {31'd0, out_done},  32'd0);
        chk("reset_out_error", {31'd0, out_error}, 32'd0);
        chk("reset_out_busy",  {31'd0, out_busy},  32'd0);
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < NV; i++)
            issue(vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].data,
                  vecs[i].exp_data, vecs[i].exp_err);

        // Held request: three reads of 0x10, address disturbed during ST_WAIT.
        begin
            int   base;
            exp_t e;
            @(posedge clk); #1;
            base = cyc;
            for (int k = 0; k < 3; k++) begin
                e.data = 32'hDE55BEEF; e.err = 1'b0; e.due = base + k * (LATENCY + 2) + LATENCY + 1;
                sb.push_back(e);
            end
            in_access_type = 1'b0;
            in_access_size = 2'd0;
            for (int j = 0; j < 12; j++) begin
                in_addr = ((j % 4) == 1 || (j % 4) == 2) ? 32'h0 : 32'h10;
                in_req  = (j < 9);
                @(posedge clk); #1;
            end
            in_req = 1'b0;
            wait_drain();
        end

        // Reset landing on the edge of a scheduled write to 0x20.
        @(posedge clk); #1;
        in_access_type = 1'b1;
        in_access_size = 2'd0;
        in_addr        = 32'h20;
        in_data        = 32'h12345678;
        in_req         = 1'b1;
        @(posedge clk); #1;
        in_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_abort_done",  {31'd0, out_done},  32'd0);
        chk("rst_abort_data",  out_data, 32'd0);
        chk("rst_abort_error", {31'd0, out_error}, 32'd0);
        chk("rst_abort_busy",  {31'd0, out_busy},  32'd0);
        repeat (5) @(posedge clk);
        issue(1'b0, 2'd0, 32'h20, 32'h0, 32'h0F0F0F0F, 1'b0);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=expired required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
